// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an external PWM input.
// Ports: clk, rst_n, pwm_in, sample_en -> period_cnt, high_cnt, meas_valid, timeout, stuck_level.
module pwm_capture #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   input  logic             sample_en,
   output logic [CNT_W-1:0] period_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic             meas_valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HIGH,
      LOW
   } state_t;

   state_t           state;
   logic             sync1;
   logic             s;
   logic             s_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi_reg;
   logic [CNT_W-1:0] cnt_inc;
   logic             rise;
   logic             fall;

   // Edges only exist on sample strobes; s_d tracks the last sampled level.
   assign rise    = sample_en & s & ~s_d;
   assign fall    = sample_en & ~s & s_d;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1       <= 1'b0;
         s           <= 1'b0;
         s_d         <= 1'b0;
         cnt         <= '0;
         hi_reg      <= '0;
         state       <= IDLE;
         period_cnt  <= '0;
         high_cnt    <= '0;
         meas_valid  <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         sync1      <= pwm_in;
         s          <= sync1;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         if (sample_en) begin
            s_d <= s;
            unique case (state)
               // Wait for a low level so the first period starts on a true rise.
               IDLE: begin
                  if (!s) state <= ARMED;
               end
               ARMED: begin
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= CNT_W'(1);
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state  <= LOW;
                     hi_reg <= cnt;
                     cnt    <= cnt_inc;
                  end else if (cnt == TO_V) begin
                     state       <= IDLE;
                     timeout     <= 1'b1;
                     stuck_level <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               LOW: begin
                  // A rise wins over timeout on the same sample.
                  if (rise) begin
                     state      <= HIGH;
                     period_cnt <= cnt;
                     high_cnt   <= hi_reg;
                     meas_valid <= 1'b1;
                     cnt        <= CNT_W'(1);
                  end else if (cnt == TO_V) begin
                     state       <= IDLE;
                     timeout     <= 1'b1;
                     stuck_level <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
